// File: rtl/char_lcd_pkg.sv
// Shared types and LCD command constants for the character LCD scheduler.
package char_lcd_pkg;

    typedef enum logic [2:0] {
        StPwrWait,
        StInit,
        StLongWait,
        StArb,
        StAddr,
        StChar,
        StCmd
    } lcd_state_e;

    // Power-on initialisation sequence
    localparam logic [7:0] CmdFuncSet   = 8'h38;
    localparam logic [7:0] CmdDispOn    = 8'h0C;
    localparam logic [7:0] CmdEntryMode = 8'h06;
    localparam logic [7:0] CmdClear     = 8'h01;

    // DDRAM address of the first column of each line
    localparam logic [7:0] AddrLine0 = 8'h80;
    localparam logic [7:0] AddrLine1 = 8'hC0;

    // Commands that need the extra long wait afterwards
    localparam logic [7:0] LongCmdClear = 8'h01;
    localparam logic [7:0] LongCmdHome  = 8'h02;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = CmdFuncSet;
            2'd1:    b = CmdDispOn;
            2'd2:    b = CmdEntryMode;
            default: b = CmdClear;
        endcase
        return b;
    endfunction

    function automatic logic is_long_cmd(input logic [7:0] b);
        return (b == LongCmdClear) || (b == LongCmdHome);
    endfunction

endpackage

// File: rtl/char_lcd_tick.sv
// Prescaler: one-cycle tick every TICK_DIV clocks, first one TICK_DIV cycles after reset.
module char_lcd_tick #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned W = $clog2(TICK_DIV);

    logic [W-1:0] cnt_q, cnt_d;

    // Tick on the last count of each period and wrap
    always_comb begin
        tick  = (cnt_q == W'(TICK_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/char_lcd_sched.sv
// Character LCD scheduler: power-up init, continuous two-line refresh from a
// 32x8 character buffer, and raw commands arbitrated at line boundaries.
module char_lcd_sched
    import char_lcd_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 50,
    parameter int unsigned POWERUP_TICKS = 15000,
    parameter int unsigned CLR_WAIT      = 1600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       cmd_valid,
    input  logic [7:0] cmd_data,
    output logic       cmd_ready,
    output logic       init_done,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_db
);

    localparam int unsigned WaitMax = (POWERUP_TICKS > CLR_WAIT) ? POWERUP_TICKS : CLR_WAIT;
    localparam int unsigned CntW    = $clog2(WaitMax + 1);

    logic            tick;
    lcd_state_e      state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      idx_q, idx_d;     // init step or column
    logic            line_q, line_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            init_done_q, init_done_d;
    logic [7:0]      db_q, db_d;
    logic            rs_q, rs_d;
    logic [7:0]      buf_q [32];
    logic [7:0]      buf_d [32];

    logic            xfer;
    logic [7:0]      byte_cur;
    logic            rs_cur;

    char_lcd_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Byte and register-select of the transaction the current state would issue
    always_comb begin
        xfer     = 1'b1;
        byte_cur = db_q;
        rs_cur   = rs_q;
        case (state_q)
            StInit: begin byte_cur = init_cmd(idx_q[1:0]); rs_cur = 1'b0; end
            StCmd:  begin byte_cur = cmd_q;                rs_cur = 1'b0; end
            StAddr: begin byte_cur = line_q ? AddrLine1 : AddrLine0; rs_cur = 1'b0; end
            StChar: begin byte_cur = buf_q[{line_q, idx_q}];  rs_cur = 1'b1; end
            default: xfer = 1'b0;
        endcase
    end

    // Next-state, buffer writes and bus phase sequencing
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        line_d      = line_q;
        cmd_d       = cmd_q;
        init_done_d = init_done_q;
        db_d        = db_q;
        rs_d        = rs_q;
        buf_d       = buf_q;
        cmd_ready   = 1'b0;

        if (wr_en) buf_d[wr_addr] = wr_data;

        // Keep tracking the source through phase 0 so the last phase-0 value is held
        if (xfer && phase_q == 2'd0) begin
            db_d = byte_cur;
            rs_d = rs_cur;
        end

        if (tick) begin
            case (state_q)
                StPwrWait: begin
                    if (cnt_q == CntW'(POWERUP_TICKS - 1)) begin
                        cnt_d   = '0;
                        state_d = StInit;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StLongWait: begin
                    if (cnt_q == CntW'(CLR_WAIT - 1)) begin
                        cnt_d       = '0;
                        state_d     = StArb;
                        init_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StArb: begin
                    if (cmd_valid) begin
                        cmd_d     = cmd_data;
                        cmd_ready = 1'b1;
                        state_d   = StCmd;
                    end else begin
                        state_d = StAddr;
                    end
                end
                default: begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        case (state_q)
                            StInit: begin
                                if (idx_q == 4'd3) begin
                                    idx_d   = '0;
                                    state_d = StLongWait;
                                end else begin
                                    idx_d = idx_q + 4'd1;
                                end
                            end
                            StCmd:  state_d = is_long_cmd(cmd_q) ? StLongWait : StArb;
                            StAddr: begin
                                idx_d   = '0;
                                state_d = StChar;
                            end
                            default: begin
                                if (idx_q == 4'd15) begin
                                    idx_d   = '0;
                                    line_d  = ~line_q;
                                    state_d = StArb;
                                end else begin
                                    idx_d = idx_q + 4'd1;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    // State and buffer registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StPwrWait;
            phase_q     <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            line_q      <= 1'b0;
            cmd_q       <= '0;
            init_done_q <= 1'b0;
            db_q        <= '0;
            rs_q        <= 1'b0;
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            line_q      <= line_d;
            cmd_q       <= cmd_d;
            init_done_q <= init_done_d;
            db_q        <= db_d;
            rs_q        <= rs_d;
            buf_q       <= buf_d;
        end
    end

    // Phase 0 shows the live byte; later phases hold the sampled one
    always_comb begin
        lcd_e     = (phase_q == 2'd1) || (phase_q == 2'd2);
        lcd_db    = (xfer && phase_q == 2'd0) ? byte_cur : db_q;
        lcd_rs    = (xfer && phase_q == 2'd0) ? rs_cur : rs_q;
        lcd_rw    = 1'b0;
        init_done = init_done_q;
    end

endmodule
